// File: rtl/hms_timekeeper.sv
// Time-of-day counter (HH:MM:SS) with mode/set controller and a blink code
// for the field being edited.
module hms_timekeeper #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BLINK_HALF = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] secs,
    output logic [5:0] mins,
    output logic [5:0] hours,
    output logic [1:0] enable,
    output logic       tick_1hz
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLK_TC = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_nxt;
    logic          phase;
    logic          phase_nxt;
    logic [1:0]    enable_nxt;
    logic          mode_prev;
    logic          inc_prev;
    logic          mode_edge;
    logic          inc_edge;
    logic          tc;

    assign mode_edge = btn_mode & ~mode_prev;
    assign inc_edge  = btn_inc & ~inc_prev;
    assign tc        = (state == RUN) && (presc == PRE_TC);
    assign tick_1hz  = tc;

    // Button history; held high through reset so a held button gives no edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
        end
    end

    // State, blink and field-blank code registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            blink_cnt <= '0;
            phase     <= 1'b0;
            enable    <= 2'b00;
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_nxt;
            phase     <= phase_nxt;
            enable    <= enable_nxt;
        end
    end

    // Next-state, blink sequencing and blank code; mode beats increment
    always_comb begin
        state_nxt  = state;
        blink_nxt  = blink_cnt;
        phase_nxt  = phase;
        enable_nxt = 2'b00;
        if (mode_edge) begin
            unique case (state)
                RUN:      state_nxt = SET_SEC;
                SET_SEC:  state_nxt = SET_MIN;
                SET_MIN:  state_nxt = SET_HOUR;
                SET_HOUR: state_nxt = RUN;
                default:  state_nxt = RUN;
            endcase
        end
        if (mode_edge || state == RUN || inc_edge) begin
            blink_nxt = '0;
            phase_nxt = 1'b0;
        end else if (blink_cnt == BLK_TC) begin
            blink_nxt = '0;
            phase_nxt = ~phase;
        end else begin
            blink_nxt = blink_cnt + BW'(1);
        end
        if (phase_nxt) begin
            enable_nxt = 2'(state_nxt);
        end
    end

    // Prescaler: free-running in RUN, parked at zero while setting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tc ? '0 : presc + PW'(1);
        end else begin
            presc <= '0;
        end
    end

    // Time of day: carry chain on the 1 Hz tick, per-field wrap when setting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            secs  <= 6'd0;
            mins  <= 6'd0;
            hours <= 6'd0;
        end else if (state == RUN) begin
            if (tc) begin
                if (secs == 6'd59) begin
                    secs <= 6'd0;
                    if (mins == 6'd59) begin
                        mins  <= 6'd0;
                        hours <= (hours == 6'd23) ? 6'd0 : hours + 6'd1;
                    end else begin
                        mins <= mins + 6'd1;
                    end
                end else begin
                    secs <= secs + 6'd1;
                end
            end
        end else if (inc_edge && !mode_edge) begin
            unique case (state)
                SET_SEC:  secs  <= (secs == 6'd59)  ? 6'd0 : secs + 6'd1;
                SET_MIN:  mins  <= (mins == 6'd59)  ? 6'd0 : mins + 6'd1;
                SET_HOUR: hours <= (hours == 6'd23) ? 6'd0 : hours + 6'd1;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed bench for hms_timekeeper with a cycle-level behavioural model
// feeding an expected-value queue.
module tb_hms_timekeeper;

    localparam int unsigned CH = 4;
    localparam int unsigned BH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] secs;
    logic [5:0] mins;
    logic [5:0] hours;
    logic [1:0] enable;
    logic       tick_1hz;

    hms_timekeeper #(.CLK_HZ(CH), .BLINK_HALF(BH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .secs     (secs),
        .mins     (mins),
        .hours    (hours),
        .enable   (enable),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_checks = 0;
    logic [19:0] sb_q[$];
    int          last_tick = 0;

    // model state: st 0=RUN 1=SET_SEC 2=SET_MIN 3=SET_HOUR
    int m_st = 0, m_pre = 0, m_bc = 0, m_ph = 0;
    int m_s = 0, m_m = 0, m_h = 0, m_mp = 1, m_ip = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pre = 0; m_bc = 0; m_ph = 0;
        m_s = 0; m_m = 0; m_h = 0; m_mp = 1; m_ip = 1;
    endtask

    // One clock: drive inputs, check tick, push model result, compare after edge
    task automatic cyc(input logic r, input logic m, input logic i);
        int          me;
        int          ie;
        int          t;
        logic [19:0] e;
        rst_n = r; btn_mode = m; btn_inc = i;
        t = (m_st == 0 && m_pre == CH - 1) ? 1 : 0;
        #1;
        chk("tick", 32'(tick_1hz), 32'(t));
        last_tick = int'(tick_1hz);
        if (!r) begin
            model_reset();
        end else begin
            me = (m && m_mp == 0) ? 1 : 0;
            ie = (i && m_ip == 0) ? 1 : 0;
            if (m_st == 0) begin
                if (m_pre == CH - 1) begin
                    m_pre = 0;
                    m_s++;
                    if (m_s == 60) begin
                        m_s = 0; m_m++;
                        if (m_m == 60) begin
                            m_m = 0; m_h++;
                            if (m_h == 24) m_h = 0;
                        end
                    end
                end else begin
                    m_pre++;
                end
                m_bc = 0; m_ph = 0;
            end else begin
                m_pre = 0;
                if (ie == 1 && me == 0) begin
                    if (m_st == 1) m_s = (m_s + 1) % 60;
                    if (m_st == 2) m_m = (m_m + 1) % 60;
                    if (m_st == 3) m_h = (m_h + 1) % 24;
                end
                if (ie == 1) begin
                    m_bc = 0; m_ph = 0;
                end else if (m_bc == BH - 1) begin
                    m_bc = 0; m_ph = 1 - m_ph;
                end else begin
                    m_bc++;
                end
            end
            if (me == 1) begin
                m_st = (m_st + 1) % 4; m_bc = 0; m_ph = 0;
            end
            m_mp = int'(m); m_ip = int'(i);
        end
        e = {6'(m_s), 6'(m_m), 6'(m_h), (m_ph == 1) ? 2'(m_st) : 2'd0};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("regs", 32'({secs, mins, hours, enable}), 32'(sb_q.pop_front()));
    endtask

    task automatic press_mode();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse_inc(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // first reset edge is unchecked: outputs are unknown before it
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_secs", 32'(secs), 32'd0);
        chk("rst_mins", 32'(mins), 32'd0);
        chk("rst_hours", 32'(hours), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);

        // free run: tick on cycles 4, 8, 12 after release
        for (int k = 1; k <= 12; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("run_tick", 32'(last_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            if (k % 4 == 0) chk("run_secs", 32'(secs), 32'(k / 4));
        end

        // preload 23:59:58 through the set path, checking blink codes
        press_mode();
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        chk("en_sec", 32'(enable), 32'd1);
        pulse_inc(55);
        press_mode();
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        chk("en_min", 32'(enable), 32'd2);
        pulse_inc(59);
        press_mode();
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        chk("en_hour", 32'(enable), 32'd3);
        pulse_inc(23);
        cyc(1'b1, 1'b1, 1'b0);
        chk("back_run_en", 32'(enable), 32'd0);
        chk("preload", 32'({secs, mins, hours}), 32'({6'd58, 6'd59, 6'd23}));
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("first_tick", 32'(last_tick), (k == 4) ? 32'd1 : 32'd0);
        end
        chk("t_235959", 32'({secs, mins, hours}), 32'({6'd59, 6'd59, 6'd23}));
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        chk("t_000000", 32'({secs, mins, hours}), 32'd0);

        // 61 increments in SET_SEC wrap to 1; blink alternates every 3 cycles
        press_mode();
        pulse_inc(61);
        chk("wrap_secs", 32'(secs), 32'd1);
        chk("wrap_mins", 32'(mins), 32'd0);
        chk("wrap_hours", 32'(hours), 32'd0);
        for (int k = 3; k <= 9; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("blink", 32'(enable), ((k / 3) % 2 == 1) ? 32'd1 : 32'd0);
        end

        // SET_MIN: simultaneous mode+inc -> SET_HOUR, mins untouched
        press_mode();
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("simul_state", 32'(enable), 32'd3);
        chk("simul_mins", 32'(mins), 32'd0);
        repeat (10) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("held_inc", 32'(hours), 32'd1);
        pulse_inc(14);
        chk("hours15", 32'(hours), 32'd15);

        // reset from SET_HOUR with inc held across release
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst2_time", 32'({secs, mins, hours}), 32'd0);
        chk("rst2_en", 32'(enable), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        chk("rst2_no_inc", 32'(secs), 32'd0);
        chk("rst2_en_sec", 32'(enable), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("rst2_inc", 32'(secs), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hms_timekeeper.md
Name: hms_timekeeper

Overview:
- Time-of-day counter and time-setting controller. Produces the hours, minutes and seconds values for the HH:MM:SS seven-segment display stage directly downstream.
- Also produces that stage's 2-bit field-blank code, so the field being edited blinks.
- Runs from one system clock. A prescaler derives the 1 Hz tick. Two push-button inputs drive a mode/set state machine.

Parameters:
- CLK_HZ, 50000000, clock cycles per second; the prescaler terminal count is CLK_HZ-1; minimum value 2.
- BLINK_HALF, 12500000, clock cycles per blink half-period; minimum value 1.

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset
- btn_mode  input  1  mode button, already synchronised/debounced, active-high level
- btn_inc  input  1  increment button, already synchronised/debounced, active-high level
- secs  output  6  seconds, binary 0..59
- mins  output  6  minutes, binary 0..59
- hours  output  6  hours, binary 0..23
- enable  output  2  field-blank code: 00 none, 01 secs, 10 mins, 11 hours
- tick_1hz  output  1  one-cycle pulse when the prescaler reaches its terminal count in RUN

Behaviour:
- Reset: rst_n sampled low at a rising clk edge forces the following values, all taking effect at that edge.
  - secs, mins, hours = 0; enable = 00; tick_1hz = 0.
  - State = RUN; prescaler = 0; blink counter = 0; blink phase = 0.
  - Button history registers = 1, so a button held through reset gives no edge.
  - Reset during any state or any set operation is honoured identically.
- Edge detection: mode_edge = btn_mode & ~mode_prev, and inc_edge = btn_inc & ~inc_prev, both combinational. The prev registers capture the inputs every cycle. A held button produces exactly one edge.
- States: RUN, SET_SEC, SET_MIN, SET_HOUR.
  - mode_edge steps RUN->SET_SEC->SET_MIN->SET_HOUR->RUN; there are no other transitions.
- Simultaneous events:
  - mode_edge and inc_edge in the same cycle: mode wins; the increment is discarded.
  - mode_edge in the same cycle as a prescaler terminal count: the state changes and the tick still applies, because the current state is RUN.
- RUN:
  - The prescaler counts 0..CLK_HZ-1 and wraps.
  - At count CLK_HZ-1, tick_1hz = 1 in that cycle, and at that clock edge the time advances with carry:
    - secs 59->0 with carry to mins;
    - mins 59->0 with carry to hours;
    - hours 23->0.
    - 23:59:59 -> 00:00:00 in one edge.
  - inc_edge is ignored. enable = 00.
- SET_x states:
  - The prescaler is held at 0, time does not advance, and tick_1hz = 0.
  - On inc_edge, only the selected field increments, wrapping with no carry into other fields: secs 59->0, mins 59->0, hours 23->0. The new value appears one clock after the edge cycle.
- Leaving SET_HOUR for RUN: the prescaler restarts at 0, so the first tick occurs CLK_HZ cycles after the transition edge.
- Blink:
  - In any SET_x state, the blink counter counts 0..BLINK_HALF-1. At BLINK_HALF-1 it wraps and the blink phase toggles.
  - Every entry into a SET_x state clears the blink counter and phase.
  - An inc_edge also clears both, so the field shows immediately after an edit.
  - enable = field code (SET_SEC 01, SET_MIN 10, SET_HOUR 11) when the phase is 1, otherwise 00.
  - In RUN, the blink counter and phase are held at 0.
- All outputs are registered except tick_1hz, which is a decode of the prescaler and state. Output values never leave their legal ranges.

Test Plan:
- CLK_HZ=4, reset held 3 cycles then released -> all outputs 0. tick_1hz pulses on cycles 4, 8, 12 after release. secs reads 1, 2, 3 one cycle after each pulse.
- Preload to 23:59:58 via the set path, return to RUN, run 2 ticks -> 23:59:59, then 00:00:00 with no intermediate values.
- Press mode once, then pulse inc 61 times with 2-cycle gaps -> state SET_SEC, secs wraps 59->0 and ends at 1, mins/hours unchanged. With BLINK_HALF=3, enable alternates 00/01 every 3 cycles.
- Press mode 3 times -> enable codes 01, 10, 11 in the blink-off phases. A 4th press returns to RUN, enable=00, and the first tick comes exactly CLK_HZ cycles later.
- btn_mode and btn_inc rise in the same cycle while in SET_MIN -> state becomes SET_HOUR and mins is unchanged. A btn_inc held high 10 cycles -> exactly one increment.
- Assert rst_n low for one edge while in SET_HOUR with hours=15 -> next cycle state RUN, 00:00:00, enable=00. A btn_inc held across the reset release gives no increment.
